// File: rtl/fft64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft64_pkg
// Description : Shared constants, FSM encoding, twiddle table and output
//               saturation for the 64-point forward/inverse transforms.
// Revision    : 1.0 - initial release
// ============================================================================
package fft64_pkg;

    localparam int N  = 64;
    localparam int DW = 8;
    localparam int TW = 8;
    localparam int AW = 24;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_CALC  = 2'd2;
    localparam state_t ST_WRITE = 2'd3;

    localparam logic signed [AW-1:0] c_sat_hi = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] c_sat_lo = -c_sat_hi - AW'(1);

    // First quadrant of round(127*cos(2*pi*i/64)), i = 0..16
    function automatic logic [TW-1:0] qtr_mag(input int idx);
        logic [TW-1:0] mag;
        case (idx)
            0:       mag = 8'd127;
            1:       mag = 8'd126;
            2:       mag = 8'd125;
            3:       mag = 8'd122;
            4:       mag = 8'd117;
            5:       mag = 8'd112;
            6:       mag = 8'd106;
            7:       mag = 8'd98;
            8:       mag = 8'd90;
            9:       mag = 8'd81;
            10:      mag = 8'd71;
            11:      mag = 8'd60;
            12:      mag = 8'd49;
            13:      mag = 8'd37;
            14:      mag = 8'd25;
            15:      mag = 8'd12;
            default: mag = 8'd0;
        endcase
        return mag;
    endfunction

    function automatic logic signed [TW-1:0] twiddle_cos(input logic [5:0] m);
        int            mi;
        int            idx;
        logic          neg;
        logic [TW-1:0] mag;
        mi = int'(m);
        if (mi <= 16) begin
            idx = mi;
            neg = 1'b0;
        end else if (mi <= 32) begin
            idx = 32 - mi;
            neg = 1'b1;
        end else if (mi <= 48) begin
            idx = mi - 32;
            neg = 1'b1;
        end else begin
            idx = 64 - mi;
            neg = 1'b0;
        end
        mag = qtr_mag(idx);
        return neg ? -mag : mag;
    endfunction

    // sin(theta) = cos(theta - pi/2); the 6-bit subtraction wraps the angle
    function automatic logic signed [TW-1:0] twiddle_sin(input logic [5:0] m);
        return twiddle_cos(m - 6'd16);
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] c;
        if (v > c_sat_hi)
            c = c_sat_hi;
        else if (v < c_sat_lo)
            c = c_sat_lo;
        else
            c = v;
        return c[DW-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft64_twiddle_rom.sv
`default_nettype none
// ============================================================================
// Module      : fft64_twiddle_rom
// Description : Registered 64-entry cos/sin lookup, one cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fft64_twiddle_rom
    import fft64_pkg::*;
(
    input  logic                 clk,
    input  logic [5:0]           addr,
    output logic signed [TW-1:0] cos_val,
    output logic signed [TW-1:0] sin_val
);

    always_ff @(posedge clk) begin
        cos_val <= twiddle_cos(addr);
        sin_val <= twiddle_sin(addr);
    end

endmodule
`default_nettype wire

// File: rtl/ifft64.sv
`default_nettype none
// ============================================================================
// Module      : ifft64
// Description : Serial 64-point inverse DFT, one complex MAC per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ifft64
    import fft64_pkg::*;
#(
    parameter int SHIFT = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 InEn,
    input  logic signed [DW-1:0] InR,
    input  logic signed [DW-1:0] InI,
    output logic signed [DW-1:0] OutR,
    output logic signed [DW-1:0] OutI,
    output logic                 OutEn,
    output logic                 Busy
);

    localparam logic signed [AW-1:0] c_round = AW'(1) <<< (SHIFT - 1);

    state_t r_state;
    logic   r_in_en_d;
    logic [5:0] r_k;
    logic [5:0] r_n;
    logic [6:0] r_cnt;

    logic signed [DW-1:0] r_xr [N];
    logic signed [DW-1:0] r_xi [N];
    logic signed [DW-1:0] r_yr [N];
    logic signed [DW-1:0] r_yi [N];

    logic                 r_s1_vld;
    logic signed [DW-1:0] r_s1_xr;
    logic signed [DW-1:0] r_s1_xi;
    logic signed [TW-1:0] w_cos;
    logic signed [TW-1:0] w_sin;

    logic signed [AW-1:0] r_acc_re;
    logic signed [AW-1:0] r_acc_im;

    logic signed [DW-1:0] r_out_r;
    logic signed [DW-1:0] r_out_i;
    logic                 r_out_en;

    logic [5:0]                w_m;
    logic signed [DW+TW-1:0]   w_p_rc;
    logic signed [DW+TW-1:0]   w_p_is;
    logic signed [DW+TW-1:0]   w_p_rs;
    logic signed [DW+TW-1:0]   w_p_ic;
    logic signed [AW-1:0]      w_sum_re;
    logic signed [AW-1:0]      w_sum_im;
    logic signed [AW-1:0]      w_shr_re;
    logic signed [AW-1:0]      w_shr_im;

    // Twiddle index is (n*k) mod 64; the 6-bit product truncates for free
    assign w_m = r_n * r_cnt[5:0];

    fft64_twiddle_rom u_rom (
        .clk     (clk),
        .addr    (w_m),
        .cos_val (w_cos),
        .sin_val (w_sin)
    );

    assign w_p_rc = r_s1_xr * w_cos;
    assign w_p_is = r_s1_xi * w_sin;
    assign w_p_rs = r_s1_xr * w_sin;
    assign w_p_ic = r_s1_xi * w_cos;

    assign w_sum_re = r_acc_re
                    + {{(AW-DW-TW){w_p_rc[DW+TW-1]}}, w_p_rc}
                    - {{(AW-DW-TW){w_p_is[DW+TW-1]}}, w_p_is};
    assign w_sum_im = r_acc_im
                    + {{(AW-DW-TW){w_p_rs[DW+TW-1]}}, w_p_rs}
                    + {{(AW-DW-TW){w_p_ic[DW+TW-1]}}, w_p_ic};

    assign w_shr_re = (r_acc_re + c_round) >>> SHIFT;
    assign w_shr_im = (r_acc_im + c_round) >>> SHIFT;

    always_ff @(posedge clk) begin
        r_in_en_d <= InEn;
    end

    // CALC per output n: cnt 0..63 feed stage 1, MAC lands on cnt 1..64,
    // cnt 65 writes the scaled result and clears the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_n      <= '0;
            r_cnt    <= '0;
            r_s1_vld <= 1'b0;
            r_s1_xr  <= '0;
            r_s1_xi  <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_out_en <= 1'b0;
            r_out_r  <= '0;
            r_out_i  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_out_en <= 1'b0;
                    r_out_r  <= '0;
                    r_out_i  <= '0;
                    if (InEn && !r_in_en_d) begin
                        r_state <= ST_READ;
                        r_k     <= '0;
                    end
                end

                ST_READ: begin
                    r_xr[r_k] <= InR;
                    r_xi[r_k] <= InI;
                    r_k       <= r_k + 6'd1;
                    if (r_k == 6'd63) begin
                        r_state  <= ST_CALC;
                        r_n      <= '0;
                        r_cnt    <= '0;
                        r_s1_vld <= 1'b0;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                    end
                end

                ST_CALC: begin
                    r_s1_vld <= ~r_cnt[6];
                    r_s1_xr  <= r_xr[r_cnt[5:0]];
                    r_s1_xi  <= r_xi[r_cnt[5:0]];
                    if (r_s1_vld) begin
                        r_acc_re <= w_sum_re;
                        r_acc_im <= w_sum_im;
                    end
                    if (r_cnt == 7'd65) begin
                        r_yr[r_n] <= sat_dw(w_shr_re);
                        r_yi[r_n] <= sat_dw(w_shr_im);
                        r_acc_re  <= '0;
                        r_acc_im  <= '0;
                        r_cnt     <= '0;
                        r_n       <= r_n + 6'd1;
                        if (r_n == 6'd63) begin
                            r_state  <= ST_WRITE;
                            r_out_en <= 1'b1;
                            r_out_r  <= r_yr[0];
                            r_out_i  <= r_yi[0];
                        end
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end

                ST_WRITE: begin
                    if (r_n == 6'd63) begin
                        r_state  <= ST_IDLE;
                        r_n      <= '0;
                        r_out_en <= 1'b0;
                        r_out_r  <= '0;
                        r_out_i  <= '0;
                    end else begin
                        r_n     <= r_n + 6'd1;
                        r_out_r <= r_yr[r_n + 6'd1];
                        r_out_i <= r_yi[r_n + 6'd1];
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign OutR  = r_out_r;
    assign OutI  = r_out_i;
    assign OutEn = r_out_en;
    assign Busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire
